// File: rtl/rgb_frame_tx.sv
// Parallel-RGB transmitter: streams RGB565 frames from RAM as 24-bit pixels with hsync/vsync.
// Optional test-pattern source enabled by defining RGB_FRAME_TX_PATTERN_EN.
module rgb_frame_tx #(
    parameter int unsigned H_ACTIVE       = 80,
    parameter int unsigned V_ACTIVE       = 48,
    parameter int unsigned H_BLANK        = 16,
    parameter int unsigned V_BLANK        = 4,
    parameter int unsigned FRAMES_IN_RAM  = 3,
    parameter int unsigned RAM_ADDR_WIDTH = 32,
    parameter int unsigned RAM_DATA_WIDTH = 16
) (
    input  logic                      rgb_clk,
    input  logic                      nrst,
    input  logic                      enable,
`ifdef RGB_FRAME_TX_PATTERN_EN
    input  logic                      pattern_mode,
`endif
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic                      ram_rd,
    input  logic [RAM_DATA_WIDTH-1:0] ram_data,
    output logic [23:0]               rgb,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      frame_done
);

    localparam int unsigned H_TOTAL     = H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL     = V_ACTIVE + V_BLANK;
    localparam int unsigned FRAME_WORDS = H_ACTIVE * V_ACTIVE * FRAMES_IN_RAM;
    localparam int unsigned HW          = $clog2(H_TOTAL);
    localparam int unsigned VW          = $clog2(V_TOTAL);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                    state_q, state_d;
    logic [HW-1:0]             h_cnt_q, h_cnt_d;
    logic [VW-1:0]             v_cnt_q, v_cnt_d;
    logic [RAM_ADDR_WIDTH-1:0] ptr_q, ptr_d;

    // Stage 1: RAM request plus the position attributes that travel with it.
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_q;
    logic                      ram_rd_q;
    logic                      s1_valid_q, s1_active_q, s1_hs_q, s1_vs_q, s1_last_q;

    // Stage 2: output registers.
    logic [23:0]               rgb_q, rgb_d;
    logic                      hsync_q, vsync_q, frame_done_q;

    logic                      run, h_last, v_last, frame_end;
    logic                      h_vis, v_vis, pix_active, rd_en;
    logic [23:0]               ram_rgb;

`ifdef RGB_FRAME_TX_PATTERN_EN
    logic                      pattern_q;
    logic [7:0]                frame_cnt_q;
    logic                      s1_pat_q;
    logic [23:0]               s1_pat_rgb_q;
    logic                      frame_start;
`endif

    always_comb begin
        run        = (state_q == StRun);
        h_last     = (h_cnt_q == HW'(H_TOTAL - 1));
        v_last     = (v_cnt_q == VW'(V_TOTAL - 1));
        frame_end  = run && h_last && v_last;
        h_vis      = (h_cnt_q < HW'(H_ACTIVE));
        v_vis      = (v_cnt_q < VW'(V_ACTIVE));
        pix_active = run && h_vis && v_vis;
`ifdef RGB_FRAME_TX_PATTERN_EN
        rd_en       = pix_active && !pattern_q;
        frame_start = enable && ((state_q == StIdle) || frame_end);
`else
        rd_en      = pix_active;
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = StRun;
            StRun:   if (frame_end && !enable) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (run) begin
            h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
            v_cnt_d = v_cnt_q;
            if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Pointer survives frame boundaries and idle periods so frames rotate through RAM.
    always_comb begin
        ptr_d = ptr_q;
        if (rd_en) ptr_d = (ptr_q == RAM_ADDR_WIDTH'(FRAME_WORDS - 1)) ? '0 : ptr_q + 1'b1;
    end

    always_comb begin
        ram_rgb = {ram_data[15:11], ram_data[15:13],
                   ram_data[10:5],  ram_data[10:9],
                   ram_data[4:0],   ram_data[4:2]};
        rgb_d = '0;
        if (s1_active_q) begin
`ifdef RGB_FRAME_TX_PATTERN_EN
            rgb_d = s1_pat_q ? s1_pat_rgb_q : ram_rgb;
`else
            rgb_d = ram_rgb;
`endif
        end
    end

    always_ff @(posedge rgb_clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= StIdle;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            ptr_q        <= '0;
            ram_addr_q   <= '0;
            ram_rd_q     <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_active_q  <= 1'b0;
            s1_hs_q      <= 1'b0;
            s1_vs_q      <= 1'b0;
            s1_last_q    <= 1'b0;
            rgb_q        <= '0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            ptr_q        <= ptr_d;
            if (rd_en) ram_addr_q <= ptr_q;
            ram_rd_q     <= rd_en;
            s1_valid_q   <= run;
            s1_active_q  <= pix_active;
            s1_hs_q      <= h_vis;
            s1_vs_q      <= v_vis;
            s1_last_q    <= frame_end;
            rgb_q        <= rgb_d;
            // Syncs idle low outside RUN so downstream sees blanking.
            hsync_q      <= s1_valid_q && s1_hs_q;
            vsync_q      <= s1_valid_q && s1_vs_q;
            frame_done_q <= s1_last_q;
        end
    end

`ifdef RGB_FRAME_TX_PATTERN_EN
    always_ff @(posedge rgb_clk or negedge nrst) begin
        if (!nrst) begin
            pattern_q    <= 1'b0;
            frame_cnt_q  <= '0;
            s1_pat_q     <= 1'b0;
            s1_pat_rgb_q <= '0;
        end else begin
            if (frame_start) pattern_q <= pattern_mode;
            if (frame_end) frame_cnt_q <= frame_cnt_q + 1'b1;
            s1_pat_q     <= pattern_q;
            s1_pat_rgb_q <= {8'(h_cnt_q), 8'(v_cnt_q), frame_cnt_q};
        end
    end
`endif

    assign ram_addr   = ram_addr_q;
    assign ram_rd     = ram_rd_q;
    assign rgb        = rgb_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_rgb_frame_tx.sv
// Directed bench for rgb_frame_tx: expansion, frame timing, RAM rotation, enable drop, reset.
module tb_rgb_frame_tx;

    logic        rgb_clk = 1'b0;
    logic        nrst    = 1'b0;
    logic        enable  = 1'b0;
`ifdef RGB_FRAME_TX_PATTERN_EN
    logic        pattern_mode = 1'b0;
`endif
    logic [31:0] ram_addr;
    logic        ram_rd;
    logic [15:0] ram_data;
    logic [23:0] rgb;
    logic        hsync, vsync, frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt, hs_lo, vs_lo, fd_cnt, bad;

    always #5 rgb_clk = ~rgb_clk;

    // RAM returns its own address, except two planted words for the expansion checks.
    assign ram_data = (ram_addr == 32'd1) ? 16'hFFFF :
                      (ram_addr == 32'd2) ? 16'hF800 : ram_addr[15:0];

    rgb_frame_tx #(
        .H_ACTIVE      (80),
        .V_ACTIVE      (48),
        .H_BLANK       (4),
        .V_BLANK       (2),
        .FRAMES_IN_RAM (3),
        .RAM_ADDR_WIDTH(32),
        .RAM_DATA_WIDTH(16)
    ) dut (
        .rgb_clk     (rgb_clk),
        .nrst        (nrst),
        .enable      (enable),
`ifdef RGB_FRAME_TX_PATTERN_EN
        .pattern_mode(pattern_mode),
`endif
        .ram_addr    (ram_addr),
        .ram_rd      (ram_rd),
        .ram_data    (ram_data),
        .rgb         (rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_done  (frame_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge rgb_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rgb"}, {8'h0, rgb}, 32'h0);
        check_eq({tag, "_hsync"}, {31'h0, hsync}, 32'h0);
        check_eq({tag, "_vsync"}, {31'h0, vsync}, 32'h0);
        check_eq({tag, "_ram_rd"}, {31'h0, ram_rd}, 32'h0);
        check_eq({tag, "_ram_addr"}, ram_addr, 32'h0);
        check_eq({tag, "_frame_done"}, {31'h0, frame_done}, 32'h0);
    endtask

    initial begin
        repeat (3) step();
        check_all_zero("reset");
        nrst = 1'b1;
        repeat (2) step();
        check_eq("idle_hsync", {31'h0, hsync}, 32'h0);
        check_eq("idle_ram_rd", {31'h0, ram_rd}, 32'h0);

        // First RUN cycle is after the next edge; request one edge later, pixel two later.
        enable = 1'b1;
        step();
        check_eq("run0_ram_rd", {31'h0, ram_rd}, 32'h0);
        step();
        check_eq("run1_ram_rd", {31'h0, ram_rd}, 32'h1);
        check_eq("run1_ram_addr", ram_addr, 32'd0);

        rd_cnt = 0; hs_lo = 0; vs_lo = 0; fd_cnt = 0;
        for (int i = 0; i < 4200; i++) begin
            step();
            if (ram_rd) rd_cnt++;
            if (!hsync) hs_lo++;
            if (!vsync) vs_lo++;
            if (frame_done) fd_cnt++;
            case (i)
                0: begin
                    check_eq("px0_rgb", {8'h0, rgb}, 32'h000000);
                    check_eq("px0_hsync", {31'h0, hsync}, 32'h1);
                    check_eq("px0_vsync", {31'h0, vsync}, 32'h1);
                end
                1:    check_eq("px1_ffff", {8'h0, rgb}, 32'hFFFFFF);
                2:    check_eq("px2_f800", {8'h0, rgb}, 32'hFF0000);
                3:    check_eq("px3_0003", {8'h0, rgb}, 32'h000018);
                81: begin
                    check_eq("hblank_rgb", {8'h0, rgb}, 32'h0);
                    check_eq("hblank_hsync", {31'h0, hsync}, 32'h0);
                end
                100:  check_eq("px100_0060", {8'h0, rgb}, 32'h000C00);
                4198: check_eq("fd_early", {31'h0, frame_done}, 32'h0);
                4199: begin
                    check_eq("fd_last", {31'h0, frame_done}, 32'h1);
                    check_eq("frame1_addr", ram_addr, 32'd3840);
                    check_eq("frame1_rd", {31'h0, ram_rd}, 32'h1);
                end
                default: ;
            endcase
        end
        check_eq("frame_rd_count", rd_cnt, 32'd3840);
        check_eq("frame_hs_low", hs_lo, 32'd200);
        check_eq("frame_vs_low", vs_lo, 32'd168);
        check_eq("frame_fd_count", fd_cnt, 32'd1);

        fd_cnt = 0;
        for (int i = 0; i < 4200; i++) begin
            step();
            if (frame_done) fd_cnt++;
        end
        check_eq("frame2_addr", ram_addr, 32'd7680);
        check_eq("frame2_rd", {31'h0, ram_rd}, 32'h1);
        for (int i = 0; i < 4200; i++) begin
            step();
            if (frame_done) fd_cnt++;
        end
        check_eq("frame3_wrap_addr", ram_addr, 32'd0);
        check_eq("frame3_wrap_rd", {31'h0, ram_rd}, 32'h1);
        check_eq("frames_fd_count", fd_cnt, 32'd2);

        // Counter now sits at position 1; move to the start of line 10 and drop enable.
        repeat (839) step();
        enable = 1'b0;
        rd_cnt = 0; vs_lo = 0;
        for (int j = 1; j <= 3361; j++) begin
            step();
            if (ram_rd) rd_cnt++;
            if (!vsync) vs_lo++;
            if (j == 3361) check_eq("drop_fd_last", {31'h0, frame_done}, 32'h1);
        end
        check_eq("drop_rd_count", rd_cnt, 32'd3040);
        check_eq("drop_vs_low", vs_lo, 32'd168);
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            step();
            if (ram_rd || hsync || vsync || frame_done || (rgb != 24'h0)) bad++;
        end
        check_eq("drop_idle_quiet", bad, 32'd0);

        // Restart keeps the pointer (3840); reset at pixel 40 of line 20.
        enable = 1'b1;
        repeat (1721) step();
        check_eq("restart_keep_ptr", ram_addr, 32'd5479);
        nrst = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) step();
        check_all_zero("held_rst");
        nrst = 1'b1;
        step();
        step();
        check_eq("post_rst_rd", {31'h0, ram_rd}, 32'h1);
        check_eq("post_rst_addr", ram_addr, 32'd0);

`ifdef RGB_FRAME_TX_PATTERN_EN
        nrst = 1'b0;
        pattern_mode = 1'b1;
        step();
        nrst = 1'b1;
        rd_cnt = 0;
        for (int k = 0; k < 4796; k++) begin
            step();
            if (ram_rd) rd_cnt++;
        end
        check_eq("pattern_px", {8'h0, rgb}, 32'h050701);
        check_eq("pattern_no_rd", rd_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
